// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding, default
// parameters and the saturating grant-statistics helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 4;
  localparam int STATS_W      = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    logic [STATS_W-1:0] r;
    if (v == {STATS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + STATS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: finds the first requester above rr_last,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  int               cand;
  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(rr_last) + i) % NUM_REQ;
      idx  = IDX_W'(cand);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end else begin
        found  = found;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for a shared data bus with a one-cycle turnaround
// and a bounded hold time. Optional grant statistics under BUS_ARB_STATS_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  data_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       bus_valid,
  output logic [DATA_W-1:0]          bus_data
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]         grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);

  localparam logic [HC_W-1:0]    HOLD_MAX  = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0]    HOLD_ONE  = HC_W'(1);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   rr_last_q, rr_last_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_winner;
  logic               owner_req;
  logic               others_pending;
  logic               hold_full;
  logic               new_grant;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .rr_last (rr_last_q),
    .found   (pick_found),
    .winner  (pick_winner)
  );

  // Ownership status of the current grant holder.
  always_comb begin
    owner_req      = |(req & grant_q);
    others_pending = |(req & ~grant_q);
    hold_full      = (hold_cnt_q == HOLD_MAX);
  end

  // Next-state and next-grant decision.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    rr_last_d  = rr_last_q;
    hold_cnt_d = hold_cnt_q;
    new_grant  = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (pick_found) begin
          state_d    = ST_OWN;
          grant_d    = GRANT_ONE << pick_winner;
          sel_d      = pick_winner;
          rr_last_d  = pick_winner;
          hold_cnt_d = HOLD_ONE;
          new_grant  = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          hold_cnt_d = '0;
        end
      end
      ST_OWN: begin
        // A dropped request and an expired hold both release through TURN.
        if (!owner_req || (hold_full && others_pending)) begin
          state_d    = ST_TURN;
          grant_d    = '0;
          hold_cnt_d = '0;
        end else if (hold_full) begin
          hold_cnt_d = hold_cnt_q;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      rr_last_q  <= LAST_INIT;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      rr_last_q  <= rr_last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // One-hot grant makes an OR of gated slices equivalent to a mux, and zero when idle.
  always_comb begin
    bus_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        bus_data = bus_data | data_in[i*DATA_W +: DATA_W];
      end else begin
        bus_data = bus_data;
      end
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign bus_valid = |grant_q;

`ifdef BUS_ARB_STATS_EN
  logic [STATS_W-1:0] grant_count_q, grant_count_d;

  // Count each new ownership, saturating at all-ones.
  always_comb begin
    if (new_grant) begin
      grant_count_d = sat_inc(grant_count_q);
    end else begin
      grant_count_d = grant_count_q;
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
    end
  end

  assign grant_count = grant_count_q;
`else
  logic unused_new_grant;
  assign unused_new_grant = new_grant;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a rule-level owner model predicts each
// cycle's grant/sel/data; a monitor compares after every rising edge.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     grant;
  logic [1:0]       sel;
  logic             bus_valid;
  logic [W-1:0]     bus_data;
`ifdef BUS_ARB_STATS_EN
  logic [15:0]      grant_count;
`endif

  bus_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid),
    .bus_data  (bus_data)
`ifdef BUS_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] grant;
    logic [1:0]   sel;
    int           count;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: who owns the bus, for how long, and who was granted last.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = N - 1;
  int m_sel   = 0;
  int m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_data(input logic [N-1:0] g, input logic [N*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) r = r | d[i*W +: W];
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    bit   others;
    int   c;
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
      m_sel   = 0;
      m_count = 0;
    end else if (m_owner >= 0) begin
      others = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j != m_owner && req[j]) others = 1'b1;
      end
      if (!req[m_owner] || (m_held >= MH && others)) begin
        m_owner = -1;
      end else if (m_held < MH) begin
        m_held++;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c;
          m_held  = 1;
          m_last  = c;
          m_sel   = c;
          if (m_count < 65535) m_count++;
          break;
        end
      end
    end
    e.grant = '0;
    if (m_owner >= 0) e.grant[m_owner] = 1'b1;
    e.sel   = 2'(m_sel);
    e.count = m_count;
    exp_q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("grant", 32'(grant), 32'(e.grant));
      chk("sel", 32'(sel), 32'(e.sel));
      chk("bus_valid", 32'(bus_valid), 32'(|e.grant));
      chk("bus_data", 32'(bus_data), 32'(exp_data(e.grant, data_in)));
`ifdef BUS_ARB_STATS_EN
      chk("grant_count", 32'(grant_count), 32'(e.count));
`endif
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'($urandom);
    data_in = 32'($urandom);
    repeat (3) begin
      @(negedge clk);
      req = 4'($urandom);
    end
    @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_bus_data", 32'(bus_data), 32'd0);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single requester, then release.
    data_in = {8'h00, 8'h9C, 8'hA2, 8'h54};
    req     = 4'b0010;
    @(posedge clk);
    #1;
    chk("t2_grant", 32'(grant), 32'h2);
    chk("t2_sel", 32'(sel), 32'd1);
    chk("t2_bus_data", 32'(bus_data), 32'hA2);
    repeat (3) @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Two contenders from a fresh reset.
    pulse_reset();
    req = 4'b0101;
    repeat (12) @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Everyone requests.
    pulse_reset();
    req = 4'b1111;
    repeat (26) @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Lone long holder.
    req = 4'b1000;
    repeat (12) @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of ownership.
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_valid", 32'(bus_valid), 32'd0);
`ifdef BUS_ARB_STATS_EN
    chk("t6_count_reset", 32'(grant_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    @(posedge clk);
    #1;
    chk("t6_first_grant", 32'(grant), 32'h1);
`ifdef BUS_ARB_STATS_EN
    chk("t6_count_one", 32'(grant_count), 32'd1);
`endif
    repeat (6) @(negedge clk);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      data_in = 32'($urandom);
      req     = req ^ 4'($urandom & $urandom);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
